// File: rtl/mem_resp_pkg.sv
// Shared types and limits for the mem_intf responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_resp_pkg;

    // Clear sweep in progress, or serving initiator accesses.
    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } mem_resp_state_t;

    // Legal read latency is 1..RD_LAT_MAX.
    localparam int RD_LAT_MAX = 8;
    localparam int RD_LAT_DEF = 2;

endpackage

// File: rtl/mem_intf_if.sv
// Initiator/responder bundle between a kmeans initiator and its word RAM.
// Latency: n/a (wires only).
// Backpressure: none; the responder's en/busy pins carry the access qualification.
//   master: drives addr/we/din, receives dout
//   slave : receives addr/we/din, drives dout
interface mem_intf #(
    parameter int WORD_SIZE = 64,
    parameter int ADDR_SIZE = $clog2(WORD_SIZE)
);
    logic [ADDR_SIZE-1:0] addr;
    logic                 we;
    logic [WORD_SIZE-1:0] din;
    logic [WORD_SIZE-1:0] dout;

    modport master (output addr, output we, output din, input dout);
    modport slave  (input addr, input we, input din, output dout);
endinterface

// File: rtl/mem_resp_rdpipe.sv
// Delay line for read beats (valid + data[+parity]) of STAGES register stages.
// Latency: STAGES cycles; STAGES=0 is a plain wire.
// Backpressure: none; one beat per cycle in, one per cycle out, always in order.
//   clk/rst    : clock, synchronous active-high reset (clears valid bits only)
//   in_valid   : beat entering the line     in_data  : its payload
//   out_valid  : beat leaving the line      out_data : payload of the most recent beat
module mem_resp_rdpipe #(
    parameter int STAGES = 1,
    parameter int WIDTH  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    if (STAGES == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign out_valid      = in_valid;
        assign out_data       = in_data;
    end else begin : g_regs
        logic [STAGES-1:0] vld;
        logic [WIDTH-1:0]  dat [STAGES];

        always_ff @(posedge clk) begin
            if (rst) begin
                vld <= '0;
            end else begin
                vld[0] <= in_valid;
                for (int i = 1; i < STAGES; i++) begin
                    vld[i] <= vld[i-1];
                end
            end
        end

        // Data only moves with a valid beat, so the last stage keeps the
        // most recently returned word while no beat is passing.
        always_ff @(posedge clk) begin
            if (in_valid) begin
                dat[0] <= in_data;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end

        assign out_valid = vld[STAGES-1];
        assign out_data  = dat[STAGES-1];
    end

endmodule

// File: rtl/mem_intf_responder.sv
// Memory-side end of mem_intf: single-port word RAM with zeroing sweep after reset.
// Latency: reads return RD_LAT cycles after acceptance, fully pipelined; writes take effect at the accepting edge.
// Backpressure: none; accesses offered while busy=1 are silently dropped.
//   clk, rst : clock, synchronous active-high reset
//   mem      : mem_intf slave (addr/we/din in, dout out)
//   en       : access strobe qualifying mem.addr/we/din
//   rd_valid : mem.dout carries a read beat this cycle
//   busy     : clear sweep in progress
//   par_inj  : flips the stored parity bit on write (MEM_RESP_PARITY_EN builds only)
//   par_err  : parity mismatch on the current read beat
// Optional feature macro: MEM_RESP_PARITY_EN (stores one parity bit per word).
module mem_intf_responder
    import mem_resp_pkg::*;
#(
    parameter int WORD_SIZE  = 64,
    parameter int RD_LAT     = RD_LAT_DEF,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    mem_intf.slave   mem,
    input  logic     en,
    output logic     rd_valid,
    output logic     busy,
    input  logic     par_inj,
    output logic     par_err
);

    localparam int ADDR_SIZE = $clog2(WORD_SIZE);
    localparam int DEPTH     = 2 ** ADDR_SIZE;
`ifdef MEM_RESP_PARITY_EN
    localparam int AW = WORD_SIZE + 1;
`else
    localparam int AW = WORD_SIZE;
`endif

    mem_resp_state_t      state, state_nxt;
    logic [ADDR_SIZE-1:0] clr_cnt, clr_cnt_nxt;

    logic                 wr_en;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [AW-1:0]        wr_dat;
    logic [AW-1:0]        acc_dat;
    logic                 rd_acc;

    logic [AW-1:0]        ram [DEPTH];
    logic                 rd0_vld;
    logic [AW-1:0]        rd0_dat;
    logic                 pipe_vld;
    logic [AW-1:0]        pipe_dat;
    logic                 got_beat;

`ifdef MEM_RESP_PARITY_EN
    assign acc_dat = {(^mem.din) ^ par_inj, mem.din};
`else
    logic unused_par_inj;
    assign unused_par_inj = par_inj;
    assign acc_dat        = mem.din;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT_CLEAR ? ST_CLEAR : ST_READY;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        busy        = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = mem.addr;
        wr_dat      = acc_dat;
        rd_acc      = 1'b0;
        case (state)
            ST_CLEAR: begin
                // One word zeroed per cycle, parity bit included; the
                // last word is written in the cycle that leaves the sweep.
                busy        = 1'b1;
                wr_en       = 1'b1;
                wr_addr     = clr_cnt;
                wr_dat      = '0;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == ADDR_SIZE'(DEPTH - 1)) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                wr_en  = en & mem.we;
                rd_acc = en & ~mem.we;
            end
        endcase
    end

    // Storage and the first (registered) read stage; no reset on the array.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            ram[wr_addr] <= wr_dat;
        end
        if (!rst && rd_acc) begin
            rd0_dat <= ram[mem.addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd0_vld <= 1'b0;
        end else begin
            rd0_vld <= rd_acc;
        end
    end

    mem_resp_rdpipe #(
        .STAGES (RD_LAT - 1),
        .WIDTH  (AW)
    ) u_rdpipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd0_vld),
        .in_data   (rd0_dat),
        .out_valid (pipe_vld),
        .out_data  (pipe_dat)
    );

    // The pipe's data registers are not reset, so dout is forced to zero
    // until the first beat after reset has been returned.
    always_ff @(posedge clk) begin
        if (rst) begin
            got_beat <= 1'b0;
        end else if (pipe_vld) begin
            got_beat <= 1'b1;
        end
    end

    assign rd_valid = pipe_vld;
    assign mem.dout = (pipe_vld | got_beat) ? pipe_dat[WORD_SIZE-1:0] : '0;

`ifdef MEM_RESP_PARITY_EN
    assign par_err = pipe_vld & ((^pipe_dat[WORD_SIZE-1:0]) != pipe_dat[WORD_SIZE]);
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_intf_responder.sv
// Randomised bench for mem_intf_responder against a word-array/queue reference model.
// Latency: model predicts each read beat RD_LAT cycles after acceptance.
// Backpressure: model drops every access offered while the sweep is running.
module tb_mem_intf_responder;
    import mem_resp_pkg::*;

    parameter int RD_LAT = 2;
    localparam int WS    = 64;
    localparam int AS    = 6;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst, en, par_inj;
    logic rd_valid, busy, par_err;

    mem_intf #(.WORD_SIZE(WS)) mem_if ();

    mem_intf_responder #(
        .WORD_SIZE  (WS),
        .RD_LAT     (RD_LAT),
        .INIT_CLEAR (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem      (mem_if),
        .en       (en),
        .rd_valid (rd_valid),
        .busy     (busy),
        .par_inj  (par_inj),
        .par_err  (par_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [63:0] dat;
        logic        pe;
    } rd_t;

    rd_t         q[$];
    logic [63:0] mdl [DEPTH];
    logic        mpe [DEPTH];
    int          busy_left;
    logic [63:0] last;
    int          edge_cnt;
    int          n_chk, n_fail;
    int          rdv_cnt, busy_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    // One clock: drive, model the edge, then check all outputs 1ns later.
    task automatic step(input logic r, input logic e, input logic w,
                        input logic [AS-1:0] a, input logic [63:0] d, input logic inj);
        logic exp_vld, exp_pe;
        rst         = r;
        en          = e;
        mem_if.we   = w;
        mem_if.addr = a;
        mem_if.din  = d;
        par_inj     = inj;
        @(posedge clk);
        edge_cnt++;
        if (r) begin
            q.delete();
            last      = '0;
            busy_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin
                mdl[i] = '0;
                mpe[i] = 1'b0;
            end
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (e) begin
            if (w) begin
                mdl[a] = d;
`ifdef MEM_RESP_PARITY_EN
                mpe[a] = inj;
`else
                mpe[a] = 1'b0;
`endif
            end else begin
                q.push_back('{due: edge_cnt + RD_LAT - 1, dat: mdl[a], pe: mpe[a]});
            end
        end
        exp_vld = 1'b0;
        exp_pe  = 1'b0;
        if (q.size() > 0 && q[0].due == edge_cnt) begin
            exp_vld = 1'b1;
            exp_pe  = q[0].pe;
            last    = q[0].dat;
            void'(q.pop_front());
        end
        #1;
        chk("rd_valid", 64'(rd_valid), 64'(exp_vld));
        chk("dout", mem_if.dout, last);
        chk("busy", 64'(busy), 64'(busy_left > 0));
        chk("par_err", 64'(par_err), 64'(exp_pe));
        if (rd_valid) rdv_cnt++;
        if (busy) busy_cnt++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic rnd(input int amax);
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             AS'($urandom_range(0, amax)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    endtask

    task automatic rd(input int a);
        step(1'b0, 1'b1, 1'b0, AS'(a), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    endtask

    task automatic wr(input int a, input logic [63:0] d, input logic inj);
        step(1'b0, 1'b1, 1'b1, AS'(a), d, inj);
    endtask

    initial begin
        int lat, e0;
        n_chk    = 0;
        n_fail   = 0;
        edge_cnt = 0;
        rdv_cnt  = 0;
        busy_left = 0;
        last     = '0;

        // Reset, then random accesses during the sweep (all dropped).
        busy_cnt = 0;
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < DEPTH + 4; i++) rnd(DEPTH - 1);
        chk("busy_cycles", 64'(busy_cnt), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) rd(i);
        for (int i = 0; i < RD_LAT + 1; i++) idle();

        // Write then read-after-write with latency measurement.
        wr(5, 64'hDEAD_BEEF_0123_4567, 1'b0);
        rd(5);
        e0  = edge_cnt;
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) idle();
            if (rd_valid && lat < 0) lat = edge_cnt - e0 + 1;
        end
        chk("rd_latency", 64'(lat), 64'(RD_LAT));
        chk("raw_data", mem_if.dout, 64'hDEAD_BEEF_0123_4567);

        // Back-to-back reads return in order.
        for (int i = 0; i < 8; i++) wr(i, 64'(i * 3), 1'b0);
        rdv_cnt = 0;
        for (int i = 0; i < 8; i++) rd(i);
        for (int i = 0; i < RD_LAT + 2; i++) idle();
        chk("burst_beats", 64'(rdv_cnt), 64'd8);
        chk("burst_last", mem_if.dout, 64'd21);

        // Random traffic on a small address window.
        for (int i = 0; i < 400; i++) rnd(15);
        for (int i = 0; i < RD_LAT + 1; i++) idle();

        // Reset with reads in flight: nothing may emerge afterwards.
        wr(3, 64'h1234_5678_9ABC_DEF0, 1'b0);
        rd(3);
        rd(3);
        rdv_cnt = 0;
        busy_cnt = 0;
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < RD_LAT + 3; i++) idle();
        chk("rst_flush", 64'(rdv_cnt), 64'd0);
        for (int i = 0; i < DEPTH; i++) rnd(DEPTH - 1);
        chk("busy_cycles2", 64'(busy_cnt), 64'(DEPTH));
        rdv_cnt = 0;
        for (int i = 0; i < DEPTH; i++) rd(i);
        for (int i = 0; i < RD_LAT + 1; i++) idle();
        chk("sweep_reads", 64'(rdv_cnt), 64'(DEPTH));

`ifdef MEM_RESP_PARITY_EN
        wr(9, 64'h0F0F_0000_1111_0001, 1'b1);
        wr(10, 64'h0F0F_0000_1111_0001, 1'b0);
        rd(9);
        rd(10);
        for (int i = 0; i < RD_LAT + 1; i++) idle();
`endif

        for (int i = 0; i < 200; i++) rnd(DEPTH - 1);
        for (int i = 0; i < RD_LAT + 1; i++) idle();
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
